sr_using_t_ff: RTL and testbench



---
 rtl/sr_using_t_pkg.sv | 26 ++
 rtl/t_ff.sv | 31 +++
 rtl/sr_using_t_ff.sv | 62 ++++++
 tb/tb_sr_using_t_ff.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/sr_using_t_pkg.sv
// Shared constants and the SR-to-T conversion for the T-based SR flip-flop.
package sr_using_t_pkg;

    localparam logic DEFAULT_RST_BIT = 1'b0;

    // {s, r} encoding of a single cell's request
    typedef enum logic [1:0] {
        SR_HOLD    = 2'b00,
        SR_CLR     = 2'b01,
        SR_SET     = 2'b10,
        SR_ILLEGAL = 2'b11
    } sr_code_e;

    // The toggle on SR_ILLEGAL is the deterministic response to s=r=1.
    function automatic logic sr_to_t(input logic s, input logic r, input logic q);
        logic t;
        case ({s, r})
            SR_HOLD: t = 1'b0;
            SR_CLR:  t = q;
            SR_SET:  t = ~q;
            default: t = 1'b1;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/t_ff.sv
// WIDTH-wide T flip-flop with synchronous active-high reset to RST_VAL.
module t_ff
    import sr_using_t_pkg::*;
#(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DEFAULT_RST_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q ^ t;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sr_using_t_ff.sv
// Clocked SR flip-flop vector built on a T flip-flop core.
// Optional sticky illegal-input flag: define SR_USING_T_INVALID_FLAG_EN.
module sr_using_t_ff
    import sr_using_t_pkg::*;
#(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DEFAULT_RST_BIT}}
) (
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
`ifdef SR_USING_T_INVALID_FLAG_EN
    ,
    output logic [WIDTH-1:0] invalid
`endif
);

    logic [WIDTH-1:0] t;

    always_comb begin
        t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t[i] = sr_to_t(s[i], r[i], q[i]);
        end
    end

    t_ff #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_t_ff (
        .clk (clk),
        .rst (rst),
        .t   (t),
        .q   (q)
    );

    // Derived from q so the pair can never disagree.
    assign qbar = ~q;

`ifdef SR_USING_T_INVALID_FLAG_EN
    logic [WIDTH-1:0] invalid_q;
    logic [WIDTH-1:0] invalid_d;

    always_comb begin
        invalid_d = invalid_q | (s & r);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            invalid_q <= '0;
        end else begin
            invalid_q <= invalid_d;
        end
    end

    assign invalid = invalid_q;
`endif

endmodule

// File: tb/tb_sr_using_t_ff.sv
// Directed bench for sr_using_t_ff: scalar instance and a 4-bit instance.
module tb_sr_using_t_ff;

    logic       clk;
    logic       rst1, s1, r1;
    logic       q1, qb1;
    logic       rst4;
    logic [3:0] s4, r4, q4, qb4;
`ifdef SR_USING_T_INVALID_FLAG_EN
    logic       inv1;
    logic [3:0] inv4;
`endif

    int checks = 0;
    int errors = 0;

    sr_using_t_ff #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
        .s    (s1),
        .r    (r1),
        .clk  (clk),
        .rst  (rst1),
        .q    (q1),
        .qbar (qb1)
`ifdef SR_USING_T_INVALID_FLAG_EN
        ,
        .invalid (inv1)
`endif
    );

    sr_using_t_ff #(.WIDTH(4), .RST_VAL(4'b1010)) dut4 (
        .s    (s4),
        .r    (r4),
        .clk  (clk),
        .rst  (rst4),
        .q    (q4),
        .qbar (qb4)
`ifdef SR_USING_T_INVALID_FLAG_EN
        ,
        .invalid (inv4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive1(input logic rst_v, input logic s_v, input logic r_v);
        @(negedge clk);
        rst1 = rst_v;
        s1   = s_v;
        r1   = r_v;
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic rst_v, input logic [3:0] s_v, input logic [3:0] r_v);
        @(negedge clk);
        rst4 = rst_v;
        s4   = s_v;
        r4   = r_v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst1 = 1'b0; s1 = 1'b0; r1 = 1'b0;
        rst4 = 1'b0; s4 = 4'b0; r4 = 4'b0;

        // Reset and hold
        drive1(1'b1, 1'b0, 1'b0);
        check("reset_q", {3'b0, q1}, 4'b0000);
        check("reset_qbar", {3'b0, qb1}, 4'b0001);
`ifdef SR_USING_T_INVALID_FLAG_EN
        check("reset_invalid", {3'b0, inv1}, 4'b0000);
`endif
        drive1(1'b0, 1'b0, 1'b0);
        check("hold_after_reset", {3'b0, q1}, 4'b0000);

        // Clear then set
        drive1(1'b0, 1'b0, 1'b1);
        check("clr_from_0", {3'b0, q1}, 4'b0000);
        drive1(1'b0, 1'b0, 1'b0);
        check("hold_0", {3'b0, q1}, 4'b0000);
        drive1(1'b0, 1'b1, 1'b0);
        check("set_q", {3'b0, q1}, 4'b0001);
        check("set_qbar", {3'b0, qb1}, 4'b0000);
        drive1(1'b0, 1'b0, 1'b0);
        check("hold_1", {3'b0, q1}, 4'b0001);

        // s/r change away from the edge must not reach q combinationally
        @(negedge clk);
        r1 = 1'b1;
        #1;
        check("no_comb_path", {3'b0, q1}, 4'b0001);
        r1 = 1'b0;

        // Illegal input toggles from q=1
        drive1(1'b0, 1'b1, 1'b1);
        check("illegal_1_q", {3'b0, q1}, 4'b0000);
        check("illegal_1_qbar", {3'b0, qb1}, 4'b0001);
`ifdef SR_USING_T_INVALID_FLAG_EN
        check("invalid_set", {3'b0, inv1}, 4'b0001);
`endif
        drive1(1'b0, 1'b1, 1'b1);
        check("illegal_2_q", {3'b0, q1}, 4'b0001);
        check("illegal_2_qbar", {3'b0, qb1}, 4'b0000);
        drive1(1'b0, 1'b1, 1'b1);
        check("illegal_3_q", {3'b0, q1}, 4'b0000);
        check("illegal_3_qbar", {3'b0, qb1}, 4'b0001);

        // Reset priority over set
        drive1(1'b0, 1'b1, 1'b0);
        check("set_before_rst", {3'b0, q1}, 4'b0001);
`ifdef SR_USING_T_INVALID_FLAG_EN
        check("invalid_sticky", {3'b0, inv1}, 4'b0001);
`endif
        drive1(1'b1, 1'b1, 1'b0);
        check("rst_priority", {3'b0, q1}, 4'b0000);
`ifdef SR_USING_T_INVALID_FLAG_EN
        check("invalid_cleared", {3'b0, inv1}, 4'b0000);
`endif
        drive1(1'b0, 1'b1, 1'b0);
        check("set_after_rst", {3'b0, q1}, 4'b0001);

        // Redundant set and clear
        drive1(1'b0, 1'b1, 1'b0);
        check("redundant_set", {3'b0, q1}, 4'b0001);
        drive1(1'b0, 1'b0, 1'b1);
        check("clr_from_1", {3'b0, q1}, 4'b0000);
        drive1(1'b0, 1'b0, 1'b1);
        check("redundant_clr", {3'b0, q1}, 4'b0000);
        check("redundant_clr_qbar", {3'b0, qb1}, 4'b0001);

        // Vector instance
        drive4(1'b1, 4'b0000, 4'b0000);
        check("vec_reset_q", q4, 4'b1010);
        check("vec_reset_qbar", qb4, 4'b0101);
        drive4(1'b0, 4'b0101, 4'b1000);
        check("vec_mix_q", q4, 4'b0111);
        check("vec_mix_qbar", qb4, 4'b1000);
        drive4(1'b0, 4'b1111, 4'b1111);
        check("vec_toggle_q", q4, 4'b1000);
`ifdef SR_USING_T_INVALID_FLAG_EN
        check("vec_invalid", inv4, 4'b1111);
`endif
        drive4(1'b0, 4'b0000, 4'b0000);
        check("vec_hold_q", q4, 4'b1000);
        check("vec_hold_qbar", qb4, 4'b0111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
